alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Sequential front/back end for the 32-bit combinational ALU. Accepts operations
//  over a valid/ready handshake and holds each one in an issue register that
//  drives the ALU operand and command ports. It then captures the ALU result and
//  flags into an output FIFO, which the writeback side drains with valid/ready.
//  Command encoding: ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7.
// PARAMETERS
//  OUT_DEPTH  4  output FIFO entries; power of two, >=2
//  TAG_W      4  width of opaque transaction tag carried request->response
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  reset         in   1      synchronous, active-high
//  in_valid      in   1      request valid
//  in_ready      out  1      request accepted when in_valid&&in_ready at edge
//  in_a          in   32     operand A
//  in_b          in   32     operand B
//  in_cmd        in   3      ALU command
//  in_tag        in   TAG_W  tag returned with result
//  alu_operandA  out  32     to ALU operandA (registered)
//  alu_operandB  out  32     to ALU operandB (registered)
//  alu_command   out  3      to ALU command (registered)
//  alu_result    in   32     from ALU result
//  alu_carryout  in   1      from ALU carryout
//  alu_overflow  in   1      from ALU overflow
//  out_valid     out  1      FIFO non-empty
//  out_ready     in   1      pop when out_valid&&out_ready at edge
//  out_result    out  32     head entry result
//  out_carry     out  1      head entry carry flag
//  out_overflow  out  1      head entry overflow flag
//  out_zero      out  1      head entry zero flag
//  out_tag       out  TAG_W  head entry tag
//  out_count     out  $clog2(OUT_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - Reset: iss_valid=0; alu_operandA/B=0; alu_command=0; FIFO rd/wr ptrs=0;
//    out_count=0; out_valid=0. Reset wins over every simultaneous event; an op
//    in flight or queued at reset is discarded.
//  - capture = iss_valid && (out_count<OUT_DEPTH || (out_valid&&out_ready)).
//  - in_ready = !iss_valid || capture. Combinational; no dependence on in_valid.
//  - Accept edge: load alu_operandA/B/command/tag from in_*; iss_valid<=1.
//    Capture without accept: iss_valid<=0; alu_* hold last values.
//  - Capture writes {alu_result, carry, overflow, zero, tag} at wr_ptr.
//    zero=(alu_result==0), computed here; the ALU zero port is not used.
//    carry/overflow are written as ALU values for ADD/SUB and forced 0 for all
//    other commands.
//  - Latency: accept at edge N -> ALU driven during cycle N..N+1 -> captured at
//    edge N+1 -> out_valid high after edge N+1 (one cycle) when the FIFO has room.
//  - Throughput: 1 op/cycle sustained while FIFO not full or being popped.
//  - Full: out_count==OUT_DEPTH and no pop -> capture=0, op stays in issue reg,
//    in_ready=0. Full with simultaneous pop -> capture and pop in same edge,
//    count unchanged.
//  - Empty: out_valid=0, out_* hold stale head data (don't-care); pop ignored.
//  - Simultaneous push+pop: count unchanged; ptrs both advance; wrap mod OUT_DEPTH.
//  - Order preserved; every accepted op produces exactly one response.
//  - out_* outputs come straight from FIFO storage at rd_ptr (no extra register).
//  - Held out_valid entry stays stable until popped.
// TESTING
//  1 Reset then ADD a=7 b=5 tag=3 -> out_valid 1 cycle after accept; result=12,
//    carry=0, ovf=0, zero=0, tag=3.
//  2 SUB a=5 b=5 -> result=0, zero=1, carry=1; SLT a=0xFFFFFFFF b=1 -> result=1,
//    carry=0, ovf=0.
//  3 ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf=1; XOR same operands -> ovf=0,
//    carry=0 (forced).
//  4 out_ready=0, push 6 ops with OUT_DEPTH=4 -> 4 in FIFO, 1 in issue reg,
//    in_ready=0, count=4. Then out_ready=1 -> tags drain in order, no loss/dup.
//  5 Full FIFO with in_valid and out_ready high every cycle -> one pop+one
//    capture per edge, count stays 4, 1 op/cycle.
//  6 Assert reset with FIFO holding 3 entries and issue reg valid -> next cycle
//    out_valid=0, count=0, in_ready=1, alu_* = 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - issue register and result FIFO around a 32-bit combinational ALU
module alu_issue_stage #(
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_a,
  input  logic [31:0]                  in_b,
  input  logic [2:0]                   in_cmd,
  input  logic [TAG_W-1:0]             in_tag,
  output logic [31:0]                  alu_operandA,
  output logic [31:0]                  alu_operandB,
  output logic [2:0]                   alu_command,
  input  logic [31:0]                  alu_result,
  input  logic                         alu_carryout,
  input  logic                         alu_overflow,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_result,
  output logic                         out_carry,
  output logic                         out_overflow,
  output logic                         out_zero,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(OUT_DEPTH):0]   out_count
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

  // Issue register: the op currently presented to the ALU
  logic             iss_valid_q, iss_valid_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Result FIFO pointers and occupancy
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Result FIFO storage; not reset since empty entries are don't-care
  logic [31:0]      res_q   [OUT_DEPTH];
  logic             carry_q [OUT_DEPTH];
  logic             ovf_q   [OUT_DEPTH];
  logic             zero_q  [OUT_DEPTH];
  logic [TAG_W-1:0] otag_q  [OUT_DEPTH];

  logic pop;
  logic capture;
  logic accept;
  logic arith;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes a capture when the head leaves on the same edge
  assign capture   = iss_valid_q && ((count_q < DEPTH_C) || pop);
  assign in_ready  = !iss_valid_q || capture;
  assign accept    = in_valid && in_ready;
  // Only ADD/SUB produce meaningful carry and overflow
  assign arith     = (cmd_q == 3'd0) || (cmd_q == 3'd1);

  assign alu_operandA = op_a_q;
  assign alu_operandB = op_b_q;
  assign alu_command  = cmd_q;

  assign out_result   = res_q[rd_ptr_q];
  assign out_carry    = carry_q[rd_ptr_q];
  assign out_overflow = ovf_q[rd_ptr_q];
  assign out_zero     = zero_q[rd_ptr_q];
  assign out_tag      = otag_q[rd_ptr_q];
  assign out_count    = count_q;

  // Next-state for issue register, pointers and occupancy
  always_comb begin
    iss_valid_d = iss_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cmd_d       = cmd_q;
    tag_d       = tag_q;
    if (accept) begin
      iss_valid_d = 1'b1;
      op_a_d      = in_a;
      op_b_d      = in_b;
      cmd_d       = in_cmd;
      tag_d       = in_tag;
    end else if (capture) begin
      iss_valid_d = 1'b0;
    end
    wr_ptr_d = wr_ptr_q + PW'(capture);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(capture) - CW'(pop);
  end

  // Control state; reset discards any op in flight or queued
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cmd_q       <= '0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cmd_q       <= cmd_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Write the ALU response into the FIFO slot at wr_ptr on capture
  always_ff @(posedge clk) begin
    if (!reset && capture) begin
      res_q[wr_ptr_q]   <= alu_result;
      carry_q[wr_ptr_q] <= arith ? alu_carryout : 1'b0;
      ovf_q[wr_ptr_q]   <= arith ? alu_overflow : 1'b0;
      zero_q[wr_ptr_q]  <= (alu_result == 32'd0);
      otag_q[wr_ptr_q]  <= tag_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
    logic [3:0]  tag;
  } resp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  cmd;
    logic [3:0]  tag;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_cmd;
  logic [3:0]  in_tag;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [2:0]  alu_command;
  logic [31:0] alu_result;
  logic        alu_carryout;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        out_overflow;
  logic        out_zero;
  logic [3:0]  out_tag;
  logic [2:0]  out_count;

  int    tests = 0;
  int    fails = 0;
  int    n_acc = 0;
  bit    acc_flag = 1'b0;
  resp_t exp_q[$];
  op_t   ops_q[$];
  resp_t alu_m;

  always #5 clk = ~clk;

  alu_issue_stage #(.OUT_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cmd(in_cmd), .in_tag(in_tag),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_command(alu_command),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_overflow(out_overflow),
    .out_zero(out_zero), .out_tag(out_tag), .out_count(out_count)
  );

  // Reference behaviour from the command definitions, using wide integer arithmetic
  function automatic resp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] cmd, input logic [3:0] tag);
    resp_t  m;
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    m.c = 1'b0;
    m.o = 1'b0;
    m.tag = tag;
    case (cmd)
      3'd0: begin
        m.r = a + b;
        m.c = ((ua + ub) >> 32) != 0;
        m.o = (sa + sb) != longint'($signed(m.r));
      end
      3'd1: begin
        m.r = a - b;
        m.c = (a >= b);
        m.o = (sa - sb) != longint'($signed(m.r));
      end
      3'd2: m.r = a ^ b;
      3'd3: m.r = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: m.r = a & b;
      3'd5: m.r = ~(a & b);
      3'd6: m.r = ~(a | b);
      default: m.r = a | b;
    endcase
    m.z = (m.r == 32'd0);
    return m;
  endfunction

  // External ALU: real result; carry/overflow are garbage (1) for logic ops
  always_comb begin
    alu_m        = model(alu_operandA, alu_operandB, alu_command, 4'd0);
    alu_result   = alu_m.r;
    alu_carryout = (alu_command <= 3'd1) ? alu_m.c : 1'b1;
    alu_overflow = (alu_command <= 3'd1) ? alu_m.o : 1'b1;
  end

  // Monitor: pop/compare on every handshake, push expectation on every accept
  always @(negedge clk) begin
    resp_t e;
    resp_t g;
    if (reset) begin
      exp_q.delete();
      acc_flag = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        tests++;
        g = {out_result, out_carry, out_overflow, out_zero, out_tag};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL resp_unexpected: got r=%h c=%b o=%b z=%b tag=%0d, required none", g.r, g.c, g.o, g.z, g.tag);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            fails++;
            $display("FAIL resp: got r=%h c=%b o=%b z=%b tag=%0d, required r=%h c=%b o=%b z=%b tag=%0d",
                     g.r, g.c, g.o, g.z, g.tag, e.r, e.c, e.o, e.z, e.tag);
          end
        end
      end
      acc_flag = in_valid && in_ready;
      if (acc_flag) begin
        n_acc++;
        exp_q.push_back(model(in_a, in_b, in_cmd, in_tag));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic add_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] cmd, input logic [3:0] tag);
    op_t o;
    o.a = a; o.b = b; o.cmd = cmd; o.tag = tag;
    ops_q.push_back(o);
  endtask

  // Driver: one iteration per cycle, holds an offered op until it is accepted
  task automatic pump(input int cycles, input int vpct, input int rpct, input bit chk_full);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (acc_flag && ops_q.size() > 0) void'(ops_q.pop_front());
      if (!in_valid || acc_flag) begin
        if (ops_q.size() > 0 && $urandom_range(99) < vpct) begin
          in_valid = 1'b1;
          in_a = ops_q[0].a; in_b = ops_q[0].b;
          in_cmd = ops_q[0].cmd; in_tag = ops_q[0].tag;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(99) < rpct);
      if (chk_full) begin
        @(negedge clk);
        chk("full_count", 64'(out_count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd1);
      end
    end
  endtask

  // Wait for the head entry, compare it against fixed values, then pop it
  task automatic expect_head(input string name, input logic [31:0] r, input logic c,
                             input logic o, input logic z, input logic [3:0] tag);
    int n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_head"}, {27'd0, out_result, out_carry, out_overflow, out_zero, out_tag},
        {27'd0, r, c, o, z, tag});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_base;
    int guard;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cmd = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_alu", {29'd0, alu_operandA, alu_command}, 64'd0);
    chk("rst_alu_b", 64'(alu_operandB), 64'd0);
    reset = 1'b0;

    // One-cycle latency for a single ADD
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'd7; in_b = 32'd5; in_cmd = 3'd0; in_tag = 4'd3;
    @(negedge clk);
    chk("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_valid", 64'(out_valid), 64'd1);
    expect_head("add_7_5", 32'd12, 1'b0, 1'b0, 1'b0, 4'd3);

    add_op(32'd5, 32'd5, 3'd1, 4'd1);
    pump(3, 100, 0, 1'b0);
    expect_head("sub_eq", 32'd0, 1'b1, 1'b0, 1'b1, 4'd1);
    add_op(32'hFFFF_FFFF, 32'd1, 3'd3, 4'd2);
    pump(3, 100, 0, 1'b0);
    expect_head("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0, 4'd2);
    add_op(32'h7FFF_FFFF, 32'd1, 3'd0, 4'd4);
    pump(3, 100, 0, 1'b0);
    expect_head("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'd4);
    add_op(32'h7FFF_FFFF, 32'd1, 3'd2, 4'd5);
    pump(3, 100, 0, 1'b0);
    expect_head("xor_forced", 32'h7FFF_FFFE, 1'b0, 1'b0, 1'b0, 4'd5);

    // Backpressure: six ops into a four-deep FIFO with no pops
    acc_base = n_acc;
    for (int i = 0; i < 6; i++) add_op($urandom, $urandom, 3'($urandom_range(7)), 4'(i));
    pump(10, 100, 0, 1'b0);
    chk("bp_count", 64'(out_count), 64'd4);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_accepted", 64'(n_acc - acc_base), 64'd5);
    pump(20, 100, 100, 1'b0);
    pump(10, 0, 100, 1'b0);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_all_acc", 64'(n_acc - acc_base), 64'd6);

    // Full FIFO streaming: pop and capture on the same edge every cycle
    for (int i = 0; i < 5; i++) add_op(rnd_opnd(), rnd_opnd(), 3'($urandom_range(7)), 4'(i));
    pump(10, 100, 0, 1'b0);
    chk("fill_count", 64'(out_count), 64'd4);
    for (int i = 0; i < 20; i++) add_op(rnd_opnd(), rnd_opnd(), 3'($urandom_range(7)), 4'($urandom_range(15)));
    pump(20, 100, 100, 1'b1);
    pump(10, 0, 100, 1'b0);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    // Reset with three queued entries and an op in the issue register
    for (int i = 0; i < 4; i++) add_op($urandom, $urandom, 3'($urandom_range(7)), 4'(8 + i));
    pump(5, 100, 0, 1'b0);
    chk("pre_rst_count", 64'(out_count), 64'd3);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(out_count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_alu", {29'd0, alu_operandA, alu_command}, 64'd0);
    chk("mid_rst_alu_b", 64'(alu_operandB), 64'd0);
    reset = 1'b0;
    ops_q.delete();

    // Randomized traffic with random valid and ready
    for (int i = 0; i < 200; i++) add_op(rnd_opnd(), rnd_opnd(), 3'($urandom_range(7)), 4'($urandom_range(15)));
    guard = 0;
    while (ops_q.size() > 0 && guard < 3000) begin
      pump(1, 70, 60, 1'b0);
      guard++;
    end
    chk("rand_done", 64'(ops_q.size()), 64'd0);
    pump(20, 0, 100, 1'b0);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
